// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM input-capture block: FSM state encoding.
package pwm_capture_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin plus registered rise/fall pulses.
module pwm_capture_sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

  // prev_q tracks the synchronized level every cycle, so a consumer that
  // starts listening late never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time (in prescaled ticks) of each full rise->fall->rise cycle.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int PRESCALER_BITS = 8,
  parameter int TIMER_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESCALER_BITS-1:0] prescaler_cnt,
  input  logic                      go,
  input  logic                      pwm_in,
  output logic [TIMER_BITS-1:0]     period,
  output logic [TIMER_BITS-1:0]     high_time,
  output logic                      valid,
  output logic                      timeout,
  output logic                      ovf,
  output logic                      armed
);

  logic rise, fall;

  pwm_capture_sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_t                    state_q, state_d;
  logic [PRESCALER_BITS-1:0] pre_l_q, pre_l_d, pre_n_q, pre_n_d;
  logic [TIMER_BITS-1:0]     cnt_q, cnt_d, hi_l_q, hi_l_d;
  logic [TIMER_BITS-1:0]     period_q, period_d, high_q, high_d;
  logic                      valid_q, valid_d, timeout_q, timeout_d;
  logic                      ovf_q, ovf_d, go_q;

  logic                  tick;
  logic [TIMER_BITS:0]   inc_w, add_w;
  logic [TIMER_BITS-1:0] captured, period_sat;
  logic                  sat_hit;

  always_comb begin
    tick       = (pre_n_q == pre_l_q);
    inc_w      = {1'b0, cnt_q} + {{TIMER_BITS{1'b0}}, tick};
    captured   = inc_w[TIMER_BITS] ? '1 : inc_w[TIMER_BITS-1:0];
    add_w      = {1'b0, hi_l_q} + {1'b0, captured};
    period_sat = add_w[TIMER_BITS] ? '1 : add_w[TIMER_BITS-1:0];
    sat_hit    = tick && (&cnt_q);

    state_d   = state_q;
    pre_l_d   = pre_l_q;
    pre_n_d   = pre_n_q;
    cnt_d     = cnt_q;
    hi_l_d    = hi_l_q;
    period_d  = period_q;
    high_d    = high_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    // Counters free-run only while a phase is being measured.
    if (state_q == ST_HIGH || state_q == ST_LOW) begin
      pre_n_d = tick ? '0 : pre_n_q + {{(PRESCALER_BITS-1){1'b0}}, 1'b1};
      cnt_d   = captured;
    end

    if (!go) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!go_q) begin
            pre_l_d = prescaler_cnt;
            ovf_d   = 1'b0;
            state_d = ST_WAIT_RISE;
          end
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            pre_n_d = '0;
            cnt_d   = '0;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            hi_l_d  = captured;
            pre_n_d = '0;
            cnt_d   = '0;
            state_d = ST_LOW;
          end else if (sat_hit) begin
            timeout_d = 1'b1;
            ovf_d     = 1'b1;
            state_d   = ST_WAIT_RISE;
          end
        end
        default: begin
          if (rise) begin
            period_d = period_sat;
            high_d   = hi_l_q;
            valid_d  = 1'b1;
            pre_n_d  = '0;
            cnt_d    = '0;
            state_d  = ST_HIGH;
          end else if (sat_hit) begin
            timeout_d = 1'b1;
            ovf_d     = 1'b1;
            state_d   = ST_WAIT_RISE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_l_q   <= '0;
      pre_n_q   <= '0;
      cnt_q     <= '0;
      hi_l_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_l_q   <= pre_l_d;
      pre_n_q   <= pre_n_d;
      cnt_q     <= cnt_d;
      hi_l_q    <= hi_l_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
      go_q      <= go;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign ovf       = ovf_q;
  assign armed     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: 16-bit instance via queue, 8-bit instance for saturation cases.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n, go, go8, pin, pin8;
  logic [7:0]  pre, pre8;
  logic [15:0] period, high_time;
  logic [7:0]  period8, high8;
  logic        valid, timeout, ovf, armed;
  logic        valid8, timeout8, ovf8, armed8;

  always #5 clk = ~clk;

  pwm_capture #(.PRESCALER_BITS(8), .TIMER_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .prescaler_cnt(pre), .go(go), .pwm_in(pin),
    .period(period), .high_time(high_time), .valid(valid), .timeout(timeout),
    .ovf(ovf), .armed(armed)
  );

  pwm_capture #(.PRESCALER_BITS(8), .TIMER_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .prescaler_cnt(pre8), .go(go8), .pwm_in(pin8),
    .period(period8), .high_time(high8), .valid(valid8), .timeout(timeout8),
    .ovf(ovf8), .armed(armed8)
  );

  typedef struct { logic [15:0] per; logic [15:0] hi; } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int valid_count = 0;
  int v_prev = 0;
  int v_last = 0;
  // dut8 observation while holding its pin
  int w_valid = 0;
  int w_timeout = 0;
  logic [7:0] w_per, w_hi;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (valid && timeout) begin
        vectors++; miscompares++;
        $display("FAIL valid_and_timeout both high at cycle %0d", cycle);
      end
      if (valid) begin
        valid_count++;
        v_prev = v_last;
        v_last = cycle;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid period=%0d high_time=%0d", period, high_time);
        end else begin
          e = exp_q.pop_front();
          $display("valid #%0d period=%0d (want %0d) high_time=%0d (want %0d)",
                   valid_count, period, e.per, high_time, e.hi);
          if (period !== e.per || high_time !== e.hi) begin
            miscompares++;
            $display("FAIL capture got period=%0d high=%0d want period=%0d high=%0d",
                     period, high_time, e.per, e.hi);
          end
        end
      end
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pin = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold8(input logic lvl, input int n);
    pin8 = lvl;
    repeat (n) begin
      @(posedge clk); #1;
      if (valid8) begin w_valid++; w_per = period8; w_hi = high8; end
      if (timeout8) w_timeout++;
    end
  endtask

  task automatic arm(input logic [7:0] p);
    go = 1'b0; pin = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    pre = p; go = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic drive_cycle(input int h, input int l, input int p);
    exp_t e;
    int hq, lq, s;
    hq = h / (p + 1);
    lq = l / (p + 1);
    s  = hq + lq;
    if (s > 65535) s = 65535;
    e.per = 16'(s);
    e.hi  = 16'(hq);
    exp_q.push_back(e);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain %0d captures still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; go8 = 1'b0; pin = 1'b0; pin8 = 1'b0; pre = 8'd0; pre8 = 8'd0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if ({period, high_time, valid, timeout, ovf, armed} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {period, high_time, valid, timeout, ovf, armed});
    end
    vectors++;
    if ({period8, high8, valid8, timeout8, ovf8, armed8} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs8 got %h want 0", {period8, high8, valid8, timeout8, ovf8, armed8});
    end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_basic();
    arm(8'd0);
    valid_count = 0;
    vectors++;
    if (armed !== 1'b1) begin miscompares++; $display("FAIL basic_armed got %b want 1", armed); end
    repeat (3) drive_cycle(30, 70, 0);
    hold(1'b1, 10);
    wait_drain("basic");
    vectors++;
    if (valid_count != 3) begin miscompares++; $display("FAIL basic_valid_count got %0d want 3", valid_count); end
    vectors++;
    if (v_last - v_prev != 100) begin
      miscompares++; $display("FAIL basic_valid_spacing got %0d want 100", v_last - v_prev);
    end
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf got %b want 0", ovf); end
  endtask

  task automatic test_prescaler();
    arm(8'd9);
    pre = 8'd0;  // must be ignored until the next arm
    drive_cycle(250, 750, 9);
    drive_cycle(250, 755, 9);
    drive_cycle(250, 745, 9);
    drive_cycle(253, 752, 9);
    hold(1'b1, 20);
    wait_drain("prescaler");
  endtask

  task automatic test_back_to_back();
    int p;
    p = int'($urandom_range(3, 0));
    arm(8'(p));
    for (int i = 0; i < 6; i++)
      drive_cycle(int'($urandom_range(80, 8)), int'($urandom_range(80, 8)), p);
    hold(1'b1, 10);
    wait_drain("back_to_back");
  endtask

  task automatic test_timeout();
    go8 = 1'b0; hold8(1'b0, 3);
    pre8 = 8'd0; go8 = 1'b1;
    hold8(1'b0, 5);
    w_valid = 0; w_timeout = 0;
    hold8(1'b1, 300);
    vectors++;
    if (w_timeout != 1) begin miscompares++; $display("FAIL timeout_pulses got %0d want 1", w_timeout); end
    vectors++;
    if (w_valid != 0) begin miscompares++; $display("FAIL timeout_valid got %0d want 0", w_valid); end
    vectors++;
    if ({ovf8, armed8} !== 2'b11) begin
      miscompares++; $display("FAIL timeout_ovf_armed got %b want 11", {ovf8, armed8});
    end
    hold8(1'b0, 20);
    hold8(1'b1, 30);
    hold8(1'b0, 70);
    w_valid = 0; w_timeout = 0;
    hold8(1'b1, 10);
    vectors++;
    if (w_valid != 1 || w_per !== 8'd100 || w_hi !== 8'd30 || ovf8 !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_capture got n=%0d per=%0d hi=%0d ovf=%b want n=1 per=100 hi=30 ovf=1",
               w_valid, w_per, w_hi, ovf8);
    end
    hold8(1'b1, 190);
    hold8(1'b0, 200);
    w_valid = 0; w_timeout = 0;
    hold8(1'b1, 10);
    vectors++;
    if (w_valid != 1 || w_per !== 8'd255 || w_hi !== 8'd200 || w_timeout != 0) begin
      miscompares++;
      $display("FAIL sat_period got n=%0d per=%0d hi=%0d to=%0d want n=1 per=255 hi=200 to=0",
               w_valid, w_per, w_hi, w_timeout);
    end
  endtask

  task automatic test_go_drop();
    w_valid = 0;
    hold8(1'b1, 20);
    go8 = 1'b0;
    hold8(1'b1, 2);
    vectors++;
    if ({armed8, ovf8, period8, high8} !== {1'b0, 1'b1, 8'd255, 8'd200}) begin
      miscompares++;
      $display("FAIL go_drop_hold got armed=%b ovf=%b per=%0d hi=%0d want armed=0 ovf=1 per=255 hi=200",
               armed8, ovf8, period8, high8);
    end
    hold8(1'b0, 70);
    hold8(1'b1, 30);
    hold8(1'b0, 5);
    vectors++;
    if (w_valid != 0) begin miscompares++; $display("FAIL go_drop_valid got %0d want 0", w_valid); end
    pre8 = 8'd1; go8 = 1'b1;
    hold8(1'b0, 3);
    vectors++;
    if ({ovf8, armed8} !== 2'b01) begin
      miscompares++; $display("FAIL rearm_ovf_armed got %b want 01", {ovf8, armed8});
    end
    hold8(1'b1, 60);
    hold8(1'b0, 140);
    w_valid = 0;
    hold8(1'b1, 10);
    vectors++;
    if (w_valid != 1 || w_per !== 8'd100 || w_hi !== 8'd30) begin
      miscompares++;
      $display("FAIL rearm_prescaler got n=%0d per=%0d hi=%0d want n=1 per=100 hi=30", w_valid, w_per, w_hi);
    end
  endtask

  task automatic test_async_reset();
    arm(8'd0);
    drive_cycle(30, 70, 0);
    hold(1'b1, 30);
    wait_drain("pre_reset");
    hold(1'b0, 20);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({period, high_time, valid, timeout, ovf, armed} !== 36'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0", {period, high_time, valid, timeout, ovf, armed});
    end
    vectors++;
    if ({armed8, period8} !== 9'd0) begin
      miscompares++; $display("FAIL async_reset8 got %h want 0", {armed8, period8});
    end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (armed !== 1'b1) begin miscompares++; $display("FAIL post_reset_armed got %b want 1", armed); end
    drive_cycle(40, 60, 0);
    hold(1'b1, 10);
    wait_drain("post_reset");
  endtask

  task automatic test_loopback();
    exp_t e;
    arm(8'd1);
    e.per = 16'd100;  // 50 counts * 4 clk / 2
    e.hi  = 16'd38;   // 19 counts * 4 clk / 2
    repeat (4) exp_q.push_back(e);
    for (int c = 0; c < 4; c++)
      for (int t = 0; t < 50; t++) begin
        pin = (t < 19);
        repeat (4) begin @(posedge clk); #1; end
      end
    hold(1'b1, 10);
    wait_drain("loopback");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_prescaler();
    test_back_to_back();
    test_timeout();
    test_go_drop();
    test_async_reset();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
